// File: rtl/universal_counter.sv
// universal_counter: 4-bit up/down counter with two selectable engines sharing
// one count datapath. Engine 1 presents its count directly; engine 2 presents it
// through one extra rising-edge stage. Output edge presentation follows sel_mode.
module universal_counter (
   input  logic       clkin,
   input  logic       activator,
   input  logic       module_sel,
   input  logic       sel_mode,
   input  logic       mode_updown,
   input  logic [3:0] step,
   input  logic [3:0] init,
   input  logic [3:0] target,
   output logic       done,
   output logic       start1,
   output logic       start2,
   output logic       stop1,
   output logic       stop2,
   output logic       active1,
   output logic       active2,
   output logic [3:0] counter_val
);

   localparam int unsigned W = 4;

   typedef enum logic [1:0] {IDLE, START, COUNT, STOP} state_t;

   state_t         state1, state1_n;
   state_t         state2, state2_n;
   logic [W-1:0]   count, count_n;
   logic [W-1:0]   pres2;
   logic [W-1:0]   pos_val, neg_val;
   logic           cfg_sel, cfg_dir;
   logic [W-1:0]   cfg_step, cfg_target;
   logic           sel_q, rst_q;
   logic           pause, load, done_n;
   logic           start1_n, start2_n, active1_n, active2_n, stop1_n, stop2_n;
   logic           eval_stop, eval_done;
   logic [W-1:0]   eval_next;
   logic [W:0]     sum;

   // One counting evaluation: target check, zero step, then 5-bit carry/borrow.
   always_comb begin
      sum       = cfg_dir ? ({1'b0, count} - {1'b0, cfg_step})
                          : ({1'b0, count} + {1'b0, cfg_step});
      eval_stop = 1'b0;
      eval_done = 1'b0;
      eval_next = count;
      if (count == cfg_target) begin
         eval_stop = 1'b1;
         eval_done = 1'b1;
      end else if (cfg_step == '0) begin
         eval_stop = 1'b1;
      end else if (sum[W]) begin
         eval_stop = 1'b1;
      end else begin
         eval_next = sum[W-1:0];
      end
   end

   // Next state for both engines; only the selected engine leaves IDLE.
   always_comb begin
      state1_n  = state1;
      state2_n  = state2;
      count_n   = count;
      done_n    = done;
      load      = 1'b0;
      pause     = (sel_mode != sel_q);

      case (state1)
         IDLE:  if (!module_sel) begin
                   state1_n = START;
                   load     = 1'b1;
                   count_n  = init;
                end
         START: state1_n = COUNT;
         COUNT: if (!pause) begin
                   if (eval_stop) begin
                      state1_n = STOP;
                      done_n   = eval_done;
                   end else begin
                      count_n  = eval_next;
                   end
                end
         STOP:  ;
      endcase

      case (state2)
         IDLE:  if (module_sel) begin
                   state2_n = START;
                   load     = 1'b1;
                   count_n  = init;
                end
         START: state2_n = COUNT;
         COUNT: if (!pause) begin
                   if (eval_stop) begin
                      state2_n = STOP;
                      done_n   = eval_done;
                   end else begin
                      count_n  = eval_next;
                   end
                end
         STOP:  ;
      endcase

      start1_n  = (state1_n == START);
      start2_n  = (state2_n == START);
      active1_n = (state1_n == COUNT) && !((state1 == COUNT) && pause);
      active2_n = (state2_n == COUNT) && !((state2 == COUNT) && pause);
      stop1_n   = (state1_n == STOP);
      stop2_n   = (state2_n == STOP);
   end

   // FSM state registers.
   always_ff @(posedge clkin) begin
      if (activator) begin
         state1 <= IDLE;
         state2 <= IDLE;
      end else begin
         state1 <= state1_n;
         state2 <= state2_n;
      end
   end

   // Count datapath, latched configuration and registered flags.
   always_ff @(posedge clkin) begin
      if (activator) begin
         count      <= '0;
         pres2      <= '0;
         cfg_sel    <= 1'b0;
         cfg_dir    <= 1'b0;
         cfg_step   <= '0;
         cfg_target <= '0;
         done       <= 1'b0;
         start1     <= 1'b0;
         start2     <= 1'b0;
         active1    <= 1'b0;
         active2    <= 1'b0;
         stop1      <= 1'b0;
         stop2      <= 1'b0;
         sel_q      <= sel_mode;
         rst_q      <= 1'b1;
      end else begin
         count      <= count_n;
         pres2      <= count;
         if (load) begin
            cfg_sel    <= module_sel;
            cfg_dir    <= mode_updown;
            cfg_step   <= step;
            cfg_target <= target;
         end
         done       <= done_n;
         start1     <= start1_n;
         start2     <= start2_n;
         active1    <= active1_n;
         active2    <= active2_n;
         stop1      <= stop1_n;
         stop2      <= stop2_n;
         sel_q      <= sel_mode;
         rst_q      <= 1'b0;
      end
   end

   assign pos_val = cfg_sel ? pres2 : count;

   // Falling-edge capture for negedge presentation.
   always_ff @(negedge clkin) begin
      neg_val <= pos_val;
   end

   // While reset is held the negedge copy may be stale, so force zero.
   assign counter_val = rst_q ? '0 : (sel_mode ? pos_val : neg_val);

endmodule

// File: tb/tb_universal_counter.sv
// Directed self-checking bench for universal_counter.
module tb_universal_counter;

   logic       clkin = 1'b0;
   logic       activator, module_sel, sel_mode, mode_updown;
   logic [3:0] step, init, target;
   logic       done, start1, start2, stop1, stop2, active1, active2;
   logic [3:0] counter_val;

   int checks = 0;
   int errors = 0;

   universal_counter dut (
      .clkin       (clkin),
      .activator   (activator),
      .module_sel  (module_sel),
      .sel_mode    (sel_mode),
      .mode_updown (mode_updown),
      .step        (step),
      .init        (init),
      .target      (target),
      .done        (done),
      .start1      (start1),
      .start2      (start2),
      .stop1       (stop1),
      .stop2       (stop2),
      .active1     (active1),
      .active2     (active2),
      .counter_val (counter_val)
   );

   always #5 clkin = ~clkin;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clkin);
      #2;
   endtask

   // Advance to just after the next falling edge.
   task automatic half();
      @(negedge clkin);
      #1;
   endtask

   task automatic chk_flags(input string tag, input logic [6:0] exp);
      chk(tag, 8'({done, start1, start2, stop1, stop2, active1, active2}), 8'(exp));
   endtask

   initial begin
      logic [3:0] exp_up[5];
      logic [3:0] exp_dn[5];
      exp_up = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd9};
      exp_dn = '{4'd7, 4'd5, 4'd3, 4'd1, 4'd1};

      // Engine 1, up, posedge presentation: 1,3,5,7,9 then done
      activator = 1'b1; module_sel = 1'b0; sel_mode = 1'b1; mode_updown = 1'b0;
      init = 4'd1; step = 4'd2; target = 4'd9;
      tick();
      chk("t1_rst_val", 8'(counter_val), 8'd0);
      chk_flags("t1_rst_flags", 7'b0000000);
      activator = 1'b0;
      tick();
      chk("t1_start_val", 8'(counter_val), 8'd1);
      chk_flags("t1_start_flags", 7'b0100000);
      tick();
      chk("t1_count_val", 8'(counter_val), 8'd1);
      chk_flags("t1_active_flags", 7'b0000010);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_step_val", 8'(counter_val), 8'(exp_up[i]));
         chk("t1_step_done", 8'(done), 8'd0);
      end
      tick();
      chk("t1_stop_val", 8'(counter_val), 8'd9);
      chk_flags("t1_stop_flags", 7'b1001000);
      tick();
      chk_flags("t1_hold_flags", 7'b1001000);

      // Engine 2, up, negedge presentation, overflow on first step
      activator = 1'b1; module_sel = 1'b1; sel_mode = 1'b0;
      init = 4'd15; step = 4'd2; target = 4'd9;
      tick();
      chk("t2_rst_val", 8'(counter_val), 8'd0);
      chk_flags("t2_rst_flags", 7'b0000000);
      activator = 1'b0;
      tick();
      chk("t2_start_val", 8'(counter_val), 8'd0);
      chk_flags("t2_start_flags", 7'b0010000);
      tick();
      chk("t2_active_val", 8'(counter_val), 8'd0);
      chk_flags("t2_active_flags", 7'b0000001);
      half();
      chk("t2_lag_val", 8'(counter_val), 8'd15);
      tick();
      chk("t2_ovf_val", 8'(counter_val), 8'd15);
      chk_flags("t2_ovf_flags", 7'b0000100);
      tick();
      chk("t2_hold_val", 8'(counter_val), 8'd15);
      chk_flags("t2_hold_flags", 7'b0000100);

      // Engine 1, down, underflow from 1
      activator = 1'b1; module_sel = 1'b0; sel_mode = 1'b1; mode_updown = 1'b1;
      init = 4'd9; step = 4'd2; target = 4'd15;
      tick();
      activator = 1'b0;
      tick();
      chk("t3_start_val", 8'(counter_val), 8'd9);
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_step_val", 8'(counter_val), 8'(exp_dn[i]));
      end
      tick();
      chk("t3_udf_val", 8'(counter_val), 8'd1);
      chk_flags("t3_udf_flags", 7'b0001000);

      // Engine 1, down, 15,11,7,3 reaching target
      activator = 1'b1; init = 4'd15; step = 4'd4; target = 4'd3;
      tick();
      activator = 1'b0;
      tick();
      tick();
      tick();
      chk("t4_v11", 8'(counter_val), 8'd11);
      tick();
      chk("t4_v7", 8'(counter_val), 8'd7);
      tick();
      chk("t4_v3", 8'(counter_val), 8'd3);
      chk("t4_v3_done", 8'(done), 8'd0);
      tick();
      chk_flags("t4_done_flags", 7'b1001000);

      // init equals target: done on first evaluation
      activator = 1'b1; init = 4'd6; step = 4'd1; target = 4'd6;
      tick();
      activator = 1'b0;
      tick();
      tick();
      chk_flags("t4b_active_flags", 7'b0000010);
      tick();
      chk("t4b_val", 8'(counter_val), 8'd6);
      chk_flags("t4b_done_flags", 7'b1001000);

      // sel_mode toggle mid-count: one-cycle pause, then negedge presentation
      activator = 1'b1; mode_updown = 1'b0; sel_mode = 1'b1;
      init = 4'd0; step = 4'd1; target = 4'd15;
      tick();
      activator = 1'b0;
      tick();
      tick();
      tick();
      chk("t5_v1", 8'(counter_val), 8'd1);
      tick();
      chk("t5_v2", 8'(counter_val), 8'd2);
      sel_mode = 1'b0;
      tick();
      chk("t5_pause_active", 8'(active1), 8'd0);
      half();
      chk("t5_pause_val", 8'(counter_val), 8'd2);
      tick();
      chk("t5_resume_active", 8'(active1), 8'd1);
      chk("t5_neg_lag_val", 8'(counter_val), 8'd2);
      half();
      chk("t5_neg_val", 8'(counter_val), 8'd3);

      // Reset mid-count, then restart with step 0
      activator = 1'b1;
      tick();
      chk("t6_rst_val", 8'(counter_val), 8'd0);
      chk_flags("t6_rst_flags", 7'b0000000);
      activator = 1'b0; init = 4'd5; step = 4'd0;
      tick();
      chk_flags("t6_start_flags", 7'b0100000);
      tick();
      chk_flags("t6_active_flags", 7'b0000010);
      tick();
      chk_flags("t6_stop_flags", 7'b0001000);
      half();
      chk("t6_stop_val", 8'(counter_val), 8'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
